// File: rtl/aes_128_core.sv
`default_nettype none
// ============================================================================
// Module   : aes_128_core (with leaf aes_sbox)
// Brief    : Fully pipelined AES-128 encryptor with 11-cycle latency.
//            Defining AES_128_VALID_EN adds in_valid/out_valid.
// Revision : 1.0
// ============================================================================

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    logic [7:0] bb;
    acc = 8'h00;
    sh  = a;
    bb  = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) acc = acc ^ sh;
      bb = bb >> 1;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  logic [7:0] w_sq;
  logic [7:0] w_inv;

  // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
  always_comb begin
    w_sq  = in_byte;
    w_inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      w_sq  = gf_mul(w_sq, w_sq);
      w_inv = gf_mul(w_inv, w_sq);
    end
    out_byte = w_inv
             ^ {w_inv[6:0], w_inv[7]}
             ^ {w_inv[5:0], w_inv[7:6]}
             ^ {w_inv[4:0], w_inv[7:5]}
             ^ {w_inv[3:0], w_inv[7:4]}
             ^ 8'h63;
  end

endmodule

module aes_128_core (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] state,
  input  logic [127:0] key,
`ifdef AES_128_VALID_EN
  input  logic         in_valid,
  output logic         out_valid,
`endif
  output logic [127:0] out
);

  localparam logic [10:1][7:0] c_rcon = {8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
                                         8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i lives at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    return {s[127:120], s[87:80],   s[47:40],  s[7:0],
            s[95:88],   s[55:48],   s[15:8],   s[103:96],
            s[63:56],   s[23:16],   s[111:104], s[71:64],
            s[31:24],   s[119:112], s[79:72],  s[39:32]};
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_column(s[127:96]), mix_column(s[95:64]),
            mix_column(s[63:32]),  mix_column(s[31:0])};
  endfunction

  // sub_w3 is SubWord(w3); RotWord is applied afterwards since they commute.
  function automatic logic [127:0] next_round_key(input logic [127:0] k,
                                                  input logic [31:0]  sub_w3,
                                                  input logic [7:0]   rcon);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ {sub_w3[23:0], sub_w3[31:24]} ^ {rcon, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [10:0][127:0] data_q, data_d;
  logic [9:0][127:0]  key_q, key_d;
  logic [9:0]         live_q, live_d;
  logic [10:1][127:0] w_round_key;
  wire  [10:1][127:0] w_sub_data;
  wire  [10:1][31:0]  w_sub_word;

  for (genvar r = 1; r <= 10; r++) begin : g_round
    for (genvar b = 0; b < 16; b++) begin : g_data_sbox
      aes_sbox u_sbox (
        .in_byte  (data_q[r-1][8*b +: 8]),
        .out_byte (w_sub_data[r][8*b +: 8])
      );
    end
    for (genvar b = 0; b < 4; b++) begin : g_key_sbox
      aes_sbox u_sbox (
        .in_byte  (key_q[r-1][8*b +: 8]),
        .out_byte (w_sub_word[r][8*b +: 8])
      );
    end
  end

  always_comb begin
    data_d      = '0;
    key_d       = '0;
    w_round_key = '0;
    live_d      = {live_q[8:0], 1'b1};
    data_d[0]   = state ^ key;
    key_d[0]    = key;
    for (logic [3:0] r = 4'd1; r <= 4'd10; r++) begin
      w_round_key[r] = next_round_key(key_q[r - 4'd1], w_sub_word[r], c_rcon[r]);
      if (r < 4'd10) begin
        key_d[r]  = w_round_key[r];
        data_d[r] = mix_columns(shift_rows(w_sub_data[r])) ^ w_round_key[r];
      end else begin
        data_d[r] = shift_rows(w_sub_data[r]) ^ w_round_key[r];
      end
    end
    // Zeroed stages still produce a nonzero ciphertext; hold out at 0 until
    // the first post-reset block reaches the last stage.
    if (!live_q[9]) data_d[10] = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      key_q  <= '0;
      live_q <= '0;
    end else begin
      data_q <= data_d;
      key_q  <= key_d;
      live_q <= live_d;
    end
  end

  assign out = data_q[10];

`ifdef AES_128_VALID_EN
  logic [10:0] valid_q, valid_d;

  always_comb begin
    valid_d = {valid_q[9:0], in_valid};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  assign out_valid = valid_q[10];
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes_128_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_128_core
// Brief    : Directed-vector bench for aes_128_core (FIPS-197 vectors).
// Revision : 1.0
// ============================================================================

module tb_aes_128_core;

  localparam logic [127:0] c_key_b  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] c_pt_b   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] c_ct_b   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] c_key_c1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] c_pt_c1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] c_ct_c1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] c_ct_z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] state;
  logic [127:0] key;
  logic [127:0] out;
  logic         in_valid;
`ifdef AES_128_VALID_EN
  logic         out_valid;
`endif

  int checks = 0;
  int errors = 0;

  aes_128_core dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .key       (key),
`ifdef AES_128_VALID_EN
    .in_valid  (in_valid),
    .out_valid (out_valid),
`endif
    .out       (out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [127:0] k, input logic [127:0] s, input logic v);
    key      = k;
    state    = s;
    in_valid = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive('0, '0, 1'b0);
    #3;
    checks++;
    if (out !== '0) begin
      errors++;
      $display("FAIL reset_async: out=%h expected %h", out, 128'h0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out !== '0) begin
      errors++;
      $display("FAIL reset_hold: out=%h expected %h", out, 128'h0);
    end
`ifdef AES_128_VALID_EN
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: out_valid=%b expected 0", out_valid);
    end
`endif
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (out !== '0) begin
        errors++;
        $display("FAIL post_reset_zero[%0d]: out=%h expected %h", i, out, 128'h0);
      end
    end
    @(negedge clk);
    checks++;
    if (out !== c_ct_z) begin
      errors++;
      $display("FAIL all_zero_vector: out=%h expected %h", out, c_ct_z);
    end
  endtask

  // Entered on a negedge with the all-zero vector still applied.
  task automatic test_fips_c1();
    drive(c_key_c1, c_pt_c1, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (out !== c_ct_z) begin
      errors++;
      $display("FAIL c1_latency_minus1: out=%h expected %h", out, c_ct_z);
    end
    @(negedge clk);
    checks++;
    if (out !== c_ct_c1) begin
      errors++;
      $display("FAIL fips_c1: out=%h expected %h", out, c_ct_c1);
    end
  endtask

  task automatic test_fips_b();
    drive(c_key_b, c_pt_b, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (out !== c_ct_c1) begin
      errors++;
      $display("FAIL b_latency_minus1: out=%h expected %h", out, c_ct_c1);
    end
    @(negedge clk);
    checks++;
    if (out !== c_ct_b) begin
      errors++;
      $display("FAIL fips_b: out=%h expected %h", out, c_ct_b);
    end
  endtask

  task automatic test_back_to_back();
    drive(c_key_b, c_pt_b, 1'b0);
    @(negedge clk);
    drive(c_key_c1, c_pt_c1, 1'b0);
    @(negedge clk);
    drive('0, '0, 1'b0);
    repeat (9) @(negedge clk);
    checks++;
    if (out !== c_ct_b) begin
      errors++;
      $display("FAIL b2b_first: out=%h expected %h", out, c_ct_b);
    end
    @(negedge clk);
    checks++;
    if (out !== c_ct_c1) begin
      errors++;
      $display("FAIL b2b_second: out=%h expected %h", out, c_ct_c1);
    end
    @(negedge clk);
    checks++;
    if (out !== c_ct_z) begin
      errors++;
      $display("FAIL b2b_third: out=%h expected %h", out, c_ct_z);
    end
  endtask

  task automatic test_reset_mid_stream();
    drive(c_key_b, c_pt_b, 1'b1);
    @(negedge clk);
    drive(c_key_c1, c_pt_c1, 1'b1);
    @(negedge clk);
    drive('0, '0, 1'b1);
    @(negedge clk);
    drive(c_key_b, c_pt_b, 1'b1);
    @(negedge clk);
    drive(c_key_c1, c_pt_c1, 1'b1);
    @(negedge clk);
    // Five blocks in flight; pulse reset between clock edges.
    drive(c_key_b, c_pt_b, 1'b1);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out !== '0) begin
      errors++;
      $display("FAIL midstream_async_clear: out=%h expected %h", out, 128'h0);
    end
`ifdef AES_128_VALID_EN
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midstream_valid_clear: out_valid=%b expected 0", out_valid);
    end
`endif
    #1 rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (out !== '0) begin
        errors++;
        $display("FAIL midstream_flushed[%0d]: out=%h expected %h", i, out, 128'h0);
      end
`ifdef AES_128_VALID_EN
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midstream_valid_low[%0d]: out_valid=%b expected 0", i, out_valid);
      end
`endif
    end
    @(negedge clk);
    checks++;
    if (out !== c_ct_b) begin
      errors++;
      $display("FAIL midstream_first_block: out=%h expected %h", out, c_ct_b);
    end
`ifdef AES_128_VALID_EN
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midstream_first_valid: out_valid=%b expected 1", out_valid);
    end
`endif
    drive('0, '0, 1'b0);
  endtask

`ifdef AES_128_VALID_EN
  task automatic test_valid_gaps();
    logic [127:0] ks [4];
    logic [127:0] ps [4];
    logic [127:0] cs [4];
    logic         vs [4];
    ks = '{c_key_b, c_key_c1, 128'h0, c_key_b};
    ps = '{c_pt_b,  c_pt_c1,  128'h0, c_pt_b};
    cs = '{c_ct_b,  c_ct_c1,  c_ct_z, c_ct_b};
    vs = '{1'b1, 1'b0, 1'b1, 1'b1};
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(ks[i], ps[i], vs[i]);
      @(negedge clk);
    end
    drive('0, '0, 1'b0);
    repeat (6) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap_before: out_valid=%b expected 0", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== vs[i] || out !== cs[i]) begin
        errors++;
        $display("FAIL gap_pattern[%0d]: out_valid=%b out=%h expected %b %h",
                 i, out_valid, out, vs[i], cs[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap_after: out_valid=%b expected 0", out_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_back_to_back();
    test_reset_mid_stream();
`ifdef AES_128_VALID_EN
    test_valid_gaps();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
